ecpri_eth_tx_framer: RTL and testbench
======================================

Name: ecpri_eth_tx_framer

Overview:
- Transmit-side Ethernet framer for eCPRI response packets.
- Starts when ecpri_tx raises cpri_pkt_rdy_flg, with the response already in the cpri packet RAM (port 1).
- Builds a 14-byte Ethernet header: destination MAC is the source MAC from the received-frame header RAM, source MAC is LOCAL_MAC, ethertype is 0xAEFE.
- Appends the eCPRI bytes, zero-pads to the 60-byte minimum, and streams bytes with a valid/ready handshake toward the MAC.

Parameters:
DATA_WIDTH, 8, RAM and stream byte width
ADDR_WIDTH, 16, RAM address width; also width of pkt_len and the frame byte counter
LOCAL_MAC, 48'h02_00_00_00_00_01, source MAC inserted in bytes 6..11, MSB first
MIN_FRAME, 60, minimum frame length in bytes excluding FCS
MAX_FRAME, 1514, maximum frame length in bytes excluding FCS

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset)
cpri_pkt_rdy_flg  input  1  start request; sampled only in IDLE
pkt_len  input  ADDR_WIDTH  eCPRI packet length in bytes; latched at start
addr_hdr  output  ADDR_WIDTH  header RAM address
data_hdr  inout  DATA_WIDTH  header RAM data; never driven by this block
we_hdr  output  1  header RAM write enable; tied 0
oe_hdr  output  1  header RAM output enable
addr_pkt  output  ADDR_WIDTH  cpri packet RAM address
data_pkt  inout  DATA_WIDTH  cpri packet RAM data; never driven by this block
we_pkt  output  1  cpri packet RAM write enable; tied 0
oe_pkt  output  1  cpri packet RAM output enable
tx_data  output  DATA_WIDTH  frame byte
tx_valid  output  1  tx_data valid
tx_sop  output  1  first byte of frame; qualified by tx_valid
tx_eop  output  1  last byte of frame; qualified by tx_valid
tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both high
busy  output  1  high from start until completion
done  output  1  one-cycle pulse after the eop byte is accepted
err  output  1  one-cycle pulse when a length is rejected

Behaviour:
- Reset (reset=0) is asynchronous, state to IDLE. All outputs 0: addresses, oe, tx_*, busy, done, err. Byte counter k=0.
- RAM read latency is 1 clk. Address and oe are presented in LOAD, and data is valid on the bus in WAIT.
- Start condition, in IDLE: cpri_pkt_rdy_flg=1.
  - If pkt_len==0 or 14+pkt_len>MAX_FRAME: pulse err for one cycle, stay IDLE, no frame is sent.
  - Otherwise: latch pkt_len, compute flen=max(14+pkt_len, MIN_FRAME), set k=0, busy=1, go to LOAD.
- Byte source by frame index k:
  - k=0..5: header RAM addr 6+k
  - k=6..11: LOCAL_MAC[47-8*(k-6) -: 8]
  - k=12: 0xAE; k=13: 0xFE
  - k=14..13+pkt_len: cpri packet RAM addr k-14
  - remaining k<flen: 0x00
- States:
  - IDLE -> LOAD on a valid start.
  - LOAD: for a RAM source, drive addr and oe=1 for that RAM, go to WAIT. For a constant source, load the constant into tx_data, go to SEND.
  - WAIT: capture the RAM bus into tx_data, drop oe, go to SEND.
  - SEND: tx_valid=1, tx_sop=(k==0), tx_eop=(k==flen-1). tx_data, tx_sop and tx_eop hold stable until tx_ready.
    - On accept with k==flen-1: go to DONE.
    - On accept otherwise: k<=k+1, go to LOAD.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Throughput: at most 1 byte per 2 clk for constants, 1 per 3 clk for RAM bytes; no prefetch.
- cpri_pkt_rdy_flg outside IDLE is ignored and not queued. A flag held high across DONE starts a new frame in the next IDLE cycle.
- pkt_len changes after the start are ignored.
- tx_valid never drops before accept; tx_ready without tx_valid has no effect.
- The bidirectional data ports are always high-Z from this block; the RAM drives them when oe=1 and we=0.
- Reset asserted mid-frame aborts immediately. No eop is emitted; the sink discards the partial frame.

Decomposition:
- Shared package ecpri_pkg holds:
  - ETHERTYPE_ECPRI=16'hAEFE
  - ETH_HDR_LEN=14
  - MIN_FRAME and MAX_FRAME constants
  - the state enum {IDLE, LOAD, WAIT, SEND, DONE}
- Byte-source selection (k to RAM select, address and constant) is purely combinational. Put it in sub-module eth_tx_byte_sel, with FSM and counter in the top level.

Test Plan:
- Short response: header RAM[6..11]=AA BB CC DD EE FF, pkt_len=8, payload 10..17, tx_ready=1. Expect 60 bytes: AA..FF, 02 00 00 00 00 01, AE FE, 10..17, 38 zeros; sop on byte 0, eop on byte 59, one done pulse.
- Long response: pkt_len=100. Expect flen=114 with no padding; byte 113 equals RAM[99] with eop.
- Backpressure: tx_ready toggles 1-0-0-1 randomly. Expect every byte held stable until accepted, identical byte sequence, no duplicates or drops.
- Bad length: pkt_len=0, then pkt_len=1501. Expect an err pulse for each, busy stays 0, tx_valid stays 0.
- Start while busy: re-pulse cpri_pkt_rdy_flg with pkt_len=4 during a frame. Expect it ignored and the current frame to complete unchanged.
- Reset at byte 20: assert reset=0. Expect tx_valid, busy and oe at 0 immediately. After release, a fresh start sends a complete frame with sop at byte 0.

Source files
------------

// File: rtl/ecpri_pkg.sv
// Shared constants and state encoding for the eCPRI Ethernet transmit framer.
package ecpri_pkg;

    localparam logic [15:0] ETHERTYPE_ECPRI = 16'hAEFE;
    localparam int unsigned ETH_HDR_LEN     = 14;
    localparam int unsigned MIN_FRAME       = 60;
    localparam int unsigned MAX_FRAME       = 1514;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        SEND,
        DONE
    } state_e;

endpackage

// File: rtl/eth_tx_byte_sel.sv
// Maps a frame byte index to its source: header RAM, cpri packet RAM, or a constant.
module eth_tx_byte_sel
    import ecpri_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01
) (
    input  logic [ADDR_WIDTH-1:0] k_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic                  sel_hdr_c,
    output logic                  sel_pkt_c,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic [DATA_WIDTH-1:0] const_c
);

    localparam int unsigned XW = ADDR_WIDTH + 1;

    logic [XW-1:0]         k_x;
    logic [XW-1:0]         pay_end;
    logic [ADDR_WIDTH-1:0] mac_sh;

    assign k_x     = XW'(k_i);
    assign pay_end = XW'(len_i) + XW'(ETH_HDR_LEN);
    // Bit offset of the MAC byte, MSB first: byte 6 is LOCAL_MAC[47:40].
    assign mac_sh  = (ADDR_WIDTH'(11) - k_i) << 3;

    always_comb begin
        sel_hdr_c = 1'b0;
        sel_pkt_c = 1'b0;
        addr_c    = '0;
        const_c   = '0;
        if (k_x < XW'(6)) begin
            sel_hdr_c = 1'b1;
            addr_c    = k_i + ADDR_WIDTH'(6);
        end else if (k_x < XW'(12)) begin
            const_c = DATA_WIDTH'(LOCAL_MAC >> mac_sh);
        end else if (k_x == XW'(12)) begin
            const_c = DATA_WIDTH'(ETHERTYPE_ECPRI[15:8]);
        end else if (k_x == XW'(13)) begin
            const_c = DATA_WIDTH'(ETHERTYPE_ECPRI[7:0]);
        end else if (k_x < pay_end) begin
            sel_pkt_c = 1'b1;
            addr_c    = k_i - ADDR_WIDTH'(ETH_HDR_LEN);
        end
    end

endmodule

// File: rtl/ecpri_eth_tx_framer.sv
// Ethernet framer for eCPRI responses: header from RAM and constants, payload from RAM,
// zero padding to the minimum frame, streamed one byte at a time over valid/ready.
module ecpri_eth_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter int unsigned MIN_FRAME  = ecpri_pkg::MIN_FRAME,
    parameter int unsigned MAX_FRAME  = ecpri_pkg::MAX_FRAME
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpri_pkt_rdy_flg,
    input  logic [ADDR_WIDTH-1:0] pkt_len,
    output logic [ADDR_WIDTH-1:0] addr_hdr,
    inout  wire  [DATA_WIDTH-1:0] data_hdr,
    output logic                  we_hdr,
    output logic                  oe_hdr,
    output logic [ADDR_WIDTH-1:0] addr_pkt,
    inout  wire  [DATA_WIDTH-1:0] data_pkt,
    output logic                  we_pkt,
    output logic                  oe_pkt,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_sop,
    output logic                  tx_eop,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import ecpri_pkg::*;

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned XW = ADDR_WIDTH + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] flen_q, flen_d;
    logic          ram_src_q, ram_src_d;

    logic [AW-1:0] addr_hdr_q, addr_hdr_d;
    logic [AW-1:0] addr_pkt_q, addr_pkt_d;
    logic          oe_hdr_q, oe_hdr_d;
    logic          oe_pkt_q, oe_pkt_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_sop_q, tx_sop_d;
    logic          tx_eop_q, tx_eop_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [XW-1:0] raw_len_c;
    logic [AW-1:0] flen_c;
    logic          start_bad_c;
    logic          last_c;
    logic          sel_hdr_c, sel_pkt_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] const_c;

    // Wide sum so an oversized pkt_len cannot wrap past the length check.
    assign raw_len_c   = XW'(pkt_len) + XW'(ETH_HDR_LEN);
    assign start_bad_c = (pkt_len == '0) || (raw_len_c > XW'(MAX_FRAME));
    assign flen_c      = (raw_len_c < XW'(MIN_FRAME)) ? AW'(MIN_FRAME) : AW'(raw_len_c);
    assign last_c      = (k_q == flen_q - AW'(1));

    // Source lookup follows the next index so the RAM address is on the bus during LOAD.
    eth_tx_byte_sel #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LOCAL_MAC  (LOCAL_MAC)
    ) u_byte_sel (
        .k_i       (k_d),
        .len_i     (len_d),
        .sel_hdr_c (sel_hdr_c),
        .sel_pkt_c (sel_pkt_c),
        .addr_c    (sel_addr_c),
        .const_c   (const_c)
    );

    always_comb begin : fsm_next
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        flen_d  = flen_q;
        case (state_q)
            IDLE: begin
                if (cpri_pkt_rdy_flg && !start_bad_c) begin
                    state_d = LOAD;
                    k_d     = '0;
                    len_d   = pkt_len;
                    flen_d  = flen_c;
                end
            end
            LOAD: state_d = ram_src_q ? WAIT : SEND;
            WAIT: state_d = SEND;
            SEND: begin
                if (tx_ready) begin
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + AW'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : out_next
        ram_src_d  = ram_src_q;
        addr_hdr_d = addr_hdr_q;
        addr_pkt_d = addr_pkt_q;
        oe_hdr_d   = oe_hdr_q;
        oe_pkt_d   = oe_pkt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpri_pkt_rdy_flg) begin
                    if (start_bad_c) err_d  = 1'b1;
                    else             busy_d = 1'b1;
                end
            end
            LOAD: begin
                if (!ram_src_q) tx_data_d = const_c;
            end
            WAIT: begin
                tx_data_d = oe_hdr_q ? data_hdr : data_pkt;
                oe_hdr_d  = 1'b0;
                oe_pkt_d  = 1'b0;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_sop_d   = 1'b0;
                    tx_eop_d   = 1'b0;
                    if (last_c) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (state_d == LOAD && state_q != LOAD) begin
            ram_src_d = sel_hdr_c | sel_pkt_c;
            oe_hdr_d  = sel_hdr_c;
            oe_pkt_d  = sel_pkt_c;
            if (sel_hdr_c) addr_hdr_d = sel_addr_c;
            if (sel_pkt_c) addr_pkt_d = sel_addr_c;
        end
        if (state_d == SEND && state_q != SEND) begin
            tx_valid_d = 1'b1;
            tx_sop_d   = (k_q == '0);
            tx_eop_d   = last_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            len_q      <= '0;
            flen_q     <= '0;
            ram_src_q  <= 1'b0;
            addr_hdr_q <= '0;
            addr_pkt_q <= '0;
            oe_hdr_q   <= 1'b0;
            oe_pkt_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            len_q      <= len_d;
            flen_q     <= flen_d;
            ram_src_q  <= ram_src_d;
            addr_hdr_q <= addr_hdr_d;
            addr_pkt_q <= addr_pkt_d;
            oe_hdr_q   <= oe_hdr_d;
            oe_pkt_q   <= oe_pkt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign addr_hdr = addr_hdr_q;
    assign addr_pkt = addr_pkt_q;
    assign oe_hdr   = oe_hdr_q;
    assign oe_pkt   = oe_pkt_q;
    assign we_hdr   = 1'b0;
    assign we_pkt   = 1'b0;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_sop   = tx_sop_q;
    assign tx_eop   = tx_eop_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ecpri_eth_tx_framer.sv
// Scoreboard bench for ecpri_eth_tx_framer: expected frames are built from the framing rules
// and queued at start; a monitor pops and compares every accepted byte.
`timescale 1ns/1ps
module tb_ecpri_eth_tx_framer;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        reset;
    logic        flg;
    logic [15:0] pkt_len;
    logic [15:0] addr_hdr, addr_pkt;
    wire  [7:0]  data_hdr, data_pkt;
    logic        we_hdr, oe_hdr, we_pkt, oe_pkt;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_sop, tx_eop, tx_ready;
    logic        busy, done, err;

    ecpri_eth_tx_framer dut (
        .clk              (clk),
        .reset            (reset),
        .cpri_pkt_rdy_flg (flg),
        .pkt_len          (pkt_len),
        .addr_hdr         (addr_hdr),
        .data_hdr         (data_hdr),
        .we_hdr           (we_hdr),
        .oe_hdr           (oe_hdr),
        .addr_pkt         (addr_pkt),
        .data_pkt         (data_pkt),
        .we_pkt           (we_pkt),
        .oe_pkt           (oe_pkt),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_sop           (tx_sop),
        .tx_eop           (tx_eop),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    // RAM models with one clock of read latency.
    logic [7:0] hdr_mem [0:15];
    logic [7:0] pkt_mem [0:2047];
    logic [7:0] hdr_rd, pkt_rd;
    always @(posedge clk) begin
        hdr_rd <= hdr_mem[addr_hdr[3:0]];
        pkt_rd <= pkt_mem[addr_pkt[10:0]];
    end
    assign data_hdr = (oe_hdr && !we_hdr) ? hdr_rd : 8'hzz;
    assign data_pkt = (oe_pkt && !we_pkt) ? pkt_rd : 8'hzz;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   acc_cnt = 0;
    bit   bp_en = 1'b0;
    bit   held_v = 1'b0;
    logic [9:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Expected frame straight from the framing rules.
    task automatic push_frame(input int plen);
        int flen;
        logic [47:0] mac_v;
        logic [7:0]  b;
        exp_t        e;
        mac_v = MAC;
        flen  = (14 + plen < 60) ? 60 : 14 + plen;
        for (int i = 0; i < flen; i++) begin
            if (i < 6)              b = hdr_mem[6 + i];
            else if (i < 12)        b = mac_v[47 - 8 * (i - 6) -: 8];
            else if (i == 12)       b = 8'hAE;
            else if (i == 13)       b = 8'hFE;
            else if (i < 14 + plen) b = pkt_mem[i - 14];
            else                    b = 8'h00;
            e.d   = b;
            e.sop = (i == 0);
            e.eop = (i == flen - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_mem(input int plen);
        for (int i = 6; i < 12; i++) hdr_mem[i] = 8'($urandom);
        for (int i = 0; i < plen; i++) pkt_mem[i] = 8'($urandom);
    endtask

    task automatic pulse_start(input int plen);
        @(posedge clk); #1;
        flg     = 1'b1;
        pkt_len = 16'(plen);
        @(posedge clk); #1;
        flg     = 1'b0;
        pkt_len = 16'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while ((exp_q.size() != 0 || done_cnt < target) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            fail("frame_timeout");
            exp_q.delete();
        end
        @(posedge clk); #1;
        check("done_count", done_cnt, target);
        check("busy_after_done", 32'(busy), 0);
        check("valid_after_done", 32'(tx_valid), 0);
    endtask

    task automatic send_frame(input int plen, inout int exp_done);
        fill_mem(plen);
        push_frame(plen);
        pulse_start(plen);
        exp_done++;
        wait_done(exp_done);
    endtask

    task automatic bad_start(input int plen);
        @(posedge clk); #1;
        flg     = 1'b1;
        pkt_len = 16'(plen);
        @(posedge clk); #1;
        flg = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("bad_busy", 32'(busy), 0);
        check("bad_valid", 32'(tx_valid), 0);
        @(posedge clk); #1;
        check("err_one_cycle", 32'(err), 0);
        repeat (4) @(posedge clk);
        #1;
        check("bad_still_idle", {30'd0, busy, tx_valid}, 0);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) fail("accept_timeout");
        #1;
    endtask

    // Ready driver: constant 1 or a random pattern once backpressure is enabled.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: stability while stalled, scoreboard compare on each accept.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (held_v)
                check("hold_stable", {21'd0, tx_valid, tx_data, tx_sop, tx_eop}, {21'd0, 1'b1, held});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_byte");
                end else begin
                    e = exp_q.pop_front();
                    check("frame_byte", {22'd0, tx_data, tx_sop, tx_eop}, {22'd0, e.d, e.sop, e.eop});
                end
                acc_cnt++;
                held_v = 1'b0;
            end else if (tx_valid) begin
                held_v = 1'b1;
                held   = {tx_data, tx_sop, tx_eop};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_done = 0;
        int base;
        reset   = 1'b0;
        flg     = 1'b0;
        pkt_len = 16'd0;
        for (int i = 0; i < 16; i++)   hdr_mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) pkt_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_sop_eop", {30'd0, tx_sop, tx_eop}, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done_err", {30'd0, done, err}, 0);
        check("rst_oe", {30'd0, oe_hdr, oe_pkt}, 0);
        check("rst_we", {30'd0, we_hdr, we_pkt}, 0);
        check("rst_addr_hdr", 32'(addr_hdr), 0);
        check("rst_addr_pkt", 32'(addr_pkt), 0);
        check("rst_data", 32'(tx_data), 0);
        reset = 1'b1;

        // Short response padded to 60 bytes.
        hdr_mem[6] = 8'hAA; hdr_mem[7] = 8'hBB; hdr_mem[8]  = 8'hCC;
        hdr_mem[9] = 8'hDD; hdr_mem[10] = 8'hEE; hdr_mem[11] = 8'hFF;
        for (int i = 0; i < 8; i++) pkt_mem[i] = 8'(8'h10 + i);
        push_frame(8);
        check("short_len", exp_q.size(), 60);
        pulse_start(8);
        exp_done++;
        wait_done(exp_done);

        // Long response, no padding; then the exact-minimum and one-over boundaries.
        send_frame(100, exp_done);
        send_frame(46, exp_done);
        send_frame(47, exp_done);

        // Backpressure with random lengths.
        bp_en = 1'b1;
        for (int f = 0; f < 6; f++) send_frame(int'($urandom_range(1, 120)), exp_done);
        bp_en = 1'b0;

        // Rejected lengths, then the largest legal one.
        bad_start(0);
        bad_start(1501);
        check("err_count", err_cnt, 2);
        send_frame(1500, exp_done);

        // Start request while busy is ignored.
        fill_mem(30);
        push_frame(30);
        base = acc_cnt;
        pulse_start(30);
        exp_done++;
        wait_acc(base + 10);
        flg     = 1'b1;
        pkt_len = 16'd4;
        @(posedge clk); #1;
        flg = 1'b0;
        wait_done(exp_done);
        repeat (8) @(posedge clk);
        #1;
        check("no_restart", {30'd0, busy, tx_valid}, 0);

        // Flag held across DONE launches a second frame.
        fill_mem(20);
        push_frame(20);
        push_frame(20);
        @(posedge clk); #1;
        flg     = 1'b1;
        pkt_len = 16'd20;
        begin
            int n = 0;
            while (done_cnt < exp_done + 1 && n < 5000) begin @(posedge clk); n++; end
            n = 0;
            #1;
            while (!busy && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) fail("restart_timeout");
        end
        flg = 1'b0;
        exp_done += 2;
        wait_done(exp_done);

        // Reset in the middle of a frame aborts it.
        bp_en = 1'b1;
        fill_mem(50);
        push_frame(50);
        base = acc_cnt;
        pulse_start(50);
        wait_acc(base + 20);
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(tx_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_oe", {30'd0, oe_hdr, oe_pkt}, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        bp_en = 1'b0;
        send_frame(12, exp_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
